// File: rtl/abcd_seq_checker.sv
// abcd_seq_checker: cycle-accurate checker for a ##1 b ##1 c ##2 d,
// running every overlapping attempt, with pass/fail pulses and statistics.
//
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   en            - permits new attempts to start
//   clr           - synchronous clear of flags, pulses and counters
//   a, b, c, d    - observed signals
//   pass          - one-cycle pulse, an attempt matched
//   fail          - one-cycle pulse, one or more attempts died
//   fail_stage    - [0] b missing, [1] c missing, [2] d missing
//   busy          - any attempt in flight
//   attempt_cnt, pass_cnt, fail_cnt - saturating statistics (CNT_W >= 2)
module abcd_seq_checker #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             d,
   output logic             pass,
   output logic             fail,
   output logic [2:0]       fail_stage,
   output logic             busy,
   output logic [CNT_W-1:0] attempt_cnt,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt
);

   // One flag per stage; each attempt moves exactly one stage per edge,
   // so a single bit per stage is enough to hold it.
   logic s1, s2, s3, s4;

   logic       start;
   logic       pass_next;
   logic [2:0] fs_next;
   logic [1:0] fail_inc;

   // Widen to CNT_W+1 so a carry out means the sum overflowed.
   function automatic logic [CNT_W-1:0] sat_add(
      input logic [CNT_W-1:0] cnt,
      input logic [1:0]       inc
   );
      logic [CNT_W:0] sum;
      sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
      return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

   always_comb begin
      start     = en & a;
      pass_next = s4 & d;
      fs_next   = {s4 & ~d, s2 & ~c, s1 & ~b};
      fail_inc  = {1'b0, fs_next[0]}
                + {1'b0, fs_next[1]}
                + {1'b0, fs_next[2]};
   end

   assign busy = s1 | s2 | s3 | s4;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1          <= 1'b0;
         s2          <= 1'b0;
         s3          <= 1'b0;
         s4          <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
         fail_stage  <= 3'b000;
         attempt_cnt <= '0;
         pass_cnt    <= '0;
         fail_cnt    <= '0;
      end else if (clr) begin
         // clr overrides every start, pass and fail decided this edge
         s1          <= 1'b0;
         s2          <= 1'b0;
         s3          <= 1'b0;
         s4          <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
         fail_stage  <= 3'b000;
         attempt_cnt <= '0;
         pass_cnt    <= '0;
         fail_cnt    <= '0;
      end else begin
         s1          <= start;
         s2          <= s1 & b;
         s3          <= s2 & c;
         // ##2 gap: the attempt waits one cycle with no check
         s4          <= s3;
         pass        <= pass_next;
         fail        <= |fs_next;
         fail_stage  <= fs_next;
         attempt_cnt <= sat_add(attempt_cnt, {1'b0, start});
         pass_cnt    <= sat_add(pass_cnt, {1'b0, pass_next});
         fail_cnt    <= sat_add(fail_cnt, fail_inc);
      end
   end

endmodule

// File: tb/tb_abcd_seq_checker.sv
// tb_abcd_seq_checker: directed and random stimulus against a queue-based
// reference model of the a ##1 b ##1 c ##2 d checker (CNT_W 16 and 2).
module tb_abcd_seq_checker;

   logic clk = 1'b0;
   logic rst, en, clr, a, b, c, d;

   logic        d_pass, d_fail, d_busy;
   logic [2:0]  d_fs;
   logic [15:0] d_att, d_pas, d_fal;

   logic        s_pass, s_fail, s_busy;
   logic [2:0]  s_fs;
   logic [1:0]  s_att, s_pas, s_fal;

   abcd_seq_checker #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr),
      .a(a), .b(b), .c(c), .d(d),
      .pass(d_pass), .fail(d_fail), .fail_stage(d_fs),
      .busy(d_busy), .attempt_cnt(d_att),
      .pass_cnt(d_pas), .fail_cnt(d_fal)
   );

   abcd_seq_checker #(.CNT_W(2)) dut_small (
      .clk(clk), .rst(rst), .en(en), .clr(clr),
      .a(a), .b(b), .c(c), .d(d),
      .pass(s_pass), .fail(s_fail), .fail_stage(s_fs),
      .busy(s_busy), .attempt_cnt(s_att),
      .pass_cnt(s_pas), .fail_cnt(s_fal)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: list of start-edge numbers of live attempts,
   // true event totals, and this edge's decided pulses.
   int       alive[$];
   int       edge_n = 0;
   int       t_att, t_pas, t_fal;
   bit       m_pass;
   bit [2:0] m_fs;

   function automatic int clamp(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      alive.delete();
      t_att  = 0;
      t_pas  = 0;
      t_fal  = 0;
      m_pass = 1'b0;
      m_fs   = 3'b000;
   endtask

   // Apply the check rules by attempt age: b at +1, c at +2, d at +4.
   task automatic model_edge();
      int keep[$];
      m_pass = 1'b0;
      m_fs   = 3'b000;
      foreach (alive[i]) begin
         int age;
         bit live;
         age  = edge_n - alive[i];
         live = 1'b1;
         if (age == 1 && !b) begin
            m_fs[0] = 1'b1;
            live    = 1'b0;
         end else if (age == 2 && !c) begin
            m_fs[1] = 1'b1;
            live    = 1'b0;
         end else if (age == 4) begin
            if (d) m_pass = 1'b1;
            else   m_fs[2] = 1'b1;
            live = 1'b0;
         end
         if (live) keep.push_back(alive[i]);
      end
      if (en && a) keep.push_back(edge_n);
      if (clr) begin
         model_reset();
      end else begin
         alive = keep;
         t_att += (en && a) ? 1 : 0;
         t_pas += m_pass ? 1 : 0;
         t_fal += int'(m_fs[0]) + int'(m_fs[1]) + int'(m_fs[2]);
      end
      edge_n++;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pass"}, 32'(d_pass), 32'(m_pass));
      chk({tag, ".fail"}, 32'(d_fail), 32'(|m_fs));
      chk({tag, ".fs"}, 32'(d_fs), 32'(m_fs));
      chk({tag, ".busy"}, 32'(d_busy), 32'(alive.size() != 0));
      chk({tag, ".att"}, 32'(d_att), clamp(t_att, 65535));
      chk({tag, ".pas"}, 32'(d_pas), clamp(t_pas, 65535));
      chk({tag, ".fal"}, 32'(d_fal), clamp(t_fal, 65535));
      chk({tag, ".s_att"}, 32'(s_att), clamp(t_att, 3));
      chk({tag, ".s_pas"}, 32'(s_pas), clamp(t_pas, 3));
      chk({tag, ".s_fal"}, 32'(s_fal), clamp(t_fal, 3));
   endtask

   task automatic step(input logic ia, input logic ib, input logic ic,
                       input logic id, input logic ien = 1'b1,
                       input logic iclr = 1'b0,
                       input string tag = "step");
      a   = ia;
      b   = ib;
      c   = ic;
      d   = id;
      en  = ien;
      clr = iclr;
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic mid_reset(input string tag);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk({tag, ".busy0"}, 32'(d_busy), 32'd0);
      check_all(tag);
      rst = 1'b0;
   endtask

   initial begin
      int npass;
      int att0;
      logic [31:0] r;
      rst = 1'b1;
      en  = 1'b0;
      clr = 1'b0;
      a   = 1'b0;
      b   = 1'b0;
      c   = 1'b0;
      d   = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b0;

      // single match
      step(1, 0, 0, 0, 1, 0, "m_e0");
      step(0, 1, 0, 0, 1, 0, "m_e1");
      step(0, 0, 1, 0, 1, 0, "m_e2");
      step(0, 0, 0, 0, 1, 0, "m_e3");
      step(0, 0, 0, 1, 1, 0, "m_e4");
      chk("match_pulse", 32'(d_pass), 32'd1);
      step(0, 0, 0, 0, 1, 0, "m_e5");
      chk("match_drop", 32'(d_pass), 32'd0);
      chk("match_att", 32'(d_att), 32'd1);
      chk("match_pas", 32'(d_pas), 32'd1);
      chk("match_fal", 32'(d_fal), 32'd0);

      // each failure point
      step(0, 0, 0, 0, 1, 1, "clr1");
      step(1, 0, 0, 0, 1, 0, "fb0");
      step(0, 0, 0, 0, 1, 0, "fb1");
      chk("fail_b", 32'(d_fs), 32'b001);
      step(1, 0, 0, 0, 1, 0, "fc0");
      step(0, 1, 0, 0, 1, 0, "fc1");
      step(0, 0, 0, 0, 1, 0, "fc2");
      chk("fail_c", 32'(d_fs), 32'b010);
      step(1, 0, 0, 0, 1, 0, "fd0");
      step(0, 1, 0, 0, 1, 0, "fd1");
      step(0, 0, 1, 0, 1, 0, "fd2");
      step(0, 0, 0, 0, 1, 0, "fd3");
      step(0, 0, 0, 0, 1, 0, "fd4");
      chk("fail_d", 32'(d_fs), 32'b100);
      chk("fail3_fal", 32'(d_fal), 32'd3);
      chk("fail3_pas", 32'(d_pas), 32'd0);

      // multi-fail on one edge: starts at e0, e2, e3
      step(1, 0, 0, 0, 1, 0, "mf0");
      step(0, 1, 0, 0, 1, 0, "mf1");
      step(1, 0, 1, 0, 1, 0, "mf2");
      step(1, 1, 0, 0, 1, 0, "mf3");
      step(0, 0, 0, 0, 1, 0, "mf4");
      chk("multi_fs", 32'(d_fs), 32'b111);
      chk("multi_fal", 32'(d_fal), 32'd6);

      // overlap window
      step(0, 0, 0, 0, 1, 1, "clr2");
      npass = 0;
      for (int i = 0; i < 10; i++) begin
         step(1, 1, 1, 1, 1, 0, "ovl");
         npass += d_pass ? 1 : 0;
      end
      chk("ovl_passes", npass, 32'd6);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 0, "flush");
      chk("ovl_busy", 32'(d_busy), 32'd0);
      chk("ovl_att", 32'(d_att), 32'd10);

      // en low blocks starts
      att0 = int'(d_att);
      step(1, 0, 0, 0, 0, 0, "en_off");
      chk("en_off_att", 32'(d_att), att0);
      step(0, 0, 0, 0, 1, 0, "en_idle");

      // en dropped mid-attempt
      step(1, 0, 0, 0, 1, 0, "end0");
      step(0, 1, 0, 0, 0, 0, "end1");
      step(0, 0, 1, 0, 0, 0, "end2");
      step(0, 0, 0, 0, 0, 0, "end3");
      step(0, 0, 0, 1, 0, 0, "end4");
      chk("en_drop_pass", 32'(d_pass), 32'd1);

      // clr on the pass edge
      step(1, 0, 0, 0, 1, 0, "cp0");
      step(0, 1, 0, 0, 1, 0, "cp1");
      step(0, 0, 1, 0, 1, 0, "cp2");
      step(0, 0, 0, 0, 1, 0, "cp3");
      step(0, 0, 0, 1, 1, 1, "cp4");
      chk("clr_pass", 32'(d_pass), 32'd0);
      chk("clr_att", 32'(d_att), 32'd0);
      chk("clr_pas", 32'(d_pas), 32'd0);

      // reset mid-attempt
      step(1, 0, 0, 0, 1, 0, "rm0");
      step(0, 1, 0, 0, 1, 0, "rm1");
      mid_reset("rst_mid");
      step(0, 0, 1, 0, 1, 0, "rm2");

      // saturation of the 2-bit instance
      step(0, 0, 0, 0, 1, 1, "clr3");
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1, 0, "sat");
      step(0, 0, 0, 0, 1, 0, "sat_end");
      chk("sat_small", 32'(s_fal), 32'd3);
      chk("sat_big", 32'(d_fal), 32'd5);

      // random phase
      for (int i = 0; i < 400; i++) begin
         r = $urandom;
         step(r[0] | r[1], r[2] | r[3] | r[4], r[5] | r[6] | r[7],
              r[8] | r[9], r[12:10] != 3'd0,
              $urandom_range(0, 39) == 0, "rnd");
         if ($urandom_range(0, 99) == 0) mid_reset("rnd_rst");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
